// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: redirect/MMU control, sram-like instruction bus, and
// the buffered instruction stream handed to the decode stage.
interface if_fetch_queue_if;
    // control from the PC-redirect mux and the MMU
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_i;
    logic [5:0]  mmu_ecode_i;
    logic [8:0]  mmu_esubcode_i;
    // sram-like instruction bus
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    // instruction stream towards decode
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_has_exc;
    logic [5:0]  out_ecode;
    logic [8:0]  out_esubcode;
    logic [31:0] out_badv;

    modport master (
        input  redirect_valid, redirect_pc, stall_i, mmu_ecode_i, mmu_esubcode_i,
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata,
        output out_valid, out_pc, out_inst, out_has_exc, out_ecode, out_esubcode, out_badv,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc, stall_i, mmu_ecode_i, mmu_esubcode_i,
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata,
        input  out_valid, out_pc, out_inst, out_has_exc, out_ecode, out_esubcode, out_badv,
        output out_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: pipelined requests on the instruction bus,
// returned words tagged with their PC queued in a DEPTH-entry FIFO. A redirect
// flushes everything and converts in-flight requests into a discard count.
module if_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000
) (
    input logic              clk,
    input logic              rst,
    if_fetch_queue_if.master bus
);
    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam int              QW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]     LP_DEPTH_X = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   LP_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0]   LP_MAXO    = CW'(MAX_OUTSTANDING);
    localparam logic [QW-1:0]   LP_QLAST   = QW'(MAX_OUTSTANDING - 1);
    localparam logic [5:0]      ECODE_ADEF = 6'h08;

    typedef enum logic [1:0] {ST_FETCH, ST_EXC_DRAIN, ST_EXC_HOLD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        has_exc;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } entry_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_fifo_count, r_outstanding, r_discard_cnt;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [QW-1:0] r_pcq_wr, r_pcq_rd;
    entry_t        r_fifo [DEPTH];
    logic [31:0]   r_pcq [MAX_OUTSTANDING];
    entry_t        r_head;

    logic          w_adef, w_exc_at_pc, w_can_issue, w_req, w_issue;
    logic          w_resp_drop, w_resp_take, w_exc_push, w_push, w_pop;
    logic [31:0]   w_addr;
    entry_t        w_push_entry, w_head_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_after_pop, w_count_next, w_outstanding_next;
    logic [CW:0]   w_discard_sum, w_discard_redirect;

    assign w_addr      = {r_pc[31:2], 2'b00};
    assign w_adef      = (r_pc[1:0] != 2'b00);
    assign w_exc_at_pc = w_adef || (bus.mmu_ecode_i != 6'd0);
    assign w_can_issue = (({1'b0, r_fifo_count} + {1'b0, r_outstanding}) < LP_DEPTH_X)
                         && (r_outstanding < LP_MAXO);
    assign w_issue     = w_req && bus.addr_ok;
    assign w_resp_drop = bus.data_ok && (r_discard_cnt != '0);
    assign w_resp_take = bus.data_ok && (r_discard_cnt == '0);
    assign w_push      = w_resp_take || w_exc_push;
    assign w_pop       = (r_fifo_count != '0) && bus.out_ready;

    // Fetch FSM: request gating and the exception drain/hold sequence
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_exc_push   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_exc_at_pc) begin
                    w_state_next = ST_EXC_DRAIN;
                end else begin
                    w_req = w_can_issue && !bus.stall_i && !bus.redirect_valid && !rst;
                end
            end
            ST_EXC_DRAIN: begin
                // older instructions must land in the FIFO ahead of the fault entry
                if ((r_outstanding == '0) && (r_fifo_count < LP_DEPTH)) begin
                    w_exc_push   = 1'b1;
                    w_state_next = ST_EXC_HOLD;
                end
            end
            ST_EXC_HOLD: w_state_next = ST_EXC_HOLD;
            default:     w_state_next = ST_FETCH;
        endcase
        if (bus.redirect_valid) begin
            w_state_next = ST_FETCH;
        end
    end

    // FIFO write data: either a bus response or a synthesised fault entry
    always_comb begin
        w_push_entry = '0;
        if (w_exc_push) begin
            w_push_entry.pc       = r_pc;
            w_push_entry.has_exc  = 1'b1;
            w_push_entry.ecode    = w_adef ? ECODE_ADEF : bus.mmu_ecode_i;
            w_push_entry.esubcode = w_adef ? 9'd0 : bus.mmu_esubcode_i;
            w_push_entry.badv     = w_adef ? r_pc : w_addr;
        end else begin
            w_push_entry.pc   = r_pcq[r_pcq_rd];
            w_push_entry.inst = bus.rdata;
        end
    end

    // Next FIFO occupancy, head register contents and counter updates
    always_comb begin
        w_rd_ptr_next     = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_after_pop = r_fifo_count - CW'(w_pop);
        w_count_next      = w_count_after_pop + CW'(w_push);
        if (w_count_next == '0) begin
            w_head_next = '0;
        end else if (w_count_after_pop == '0) begin
            w_head_next = w_push_entry;      // bypass when the new entry becomes head
        end else begin
            w_head_next = r_fifo[w_rd_ptr_next];
        end
        case ({w_issue, w_resp_take})
            2'b10:   w_outstanding_next = r_outstanding + CW'(1);
            2'b01:   w_outstanding_next = r_outstanding - CW'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
        // every request still on the bus at redirect will answer and must be dropped
        w_discard_sum      = {1'b0, r_discard_cnt} + {1'b0, r_outstanding};
        w_discard_redirect = (bus.data_ok && (w_discard_sum != '0)) ? w_discard_sum - (CW + 1)'(1)
                                                                    : w_discard_sum;
    end

    // In-flight PC queue storage
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    // Instruction FIFO storage
    always_ff @(posedge clk) begin
        if (w_push && !bus.redirect_valid) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    // Fetch-side state: PC, FSM, outstanding/discard counters, PC queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else if (bus.redirect_valid) begin
            r_state       <= ST_FETCH;
            r_pc          <= bus.redirect_pc;
            r_outstanding <= '0;
            r_discard_cnt <= w_discard_redirect[CW-1:0];
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            if (w_issue) begin
                r_pc     <= r_pc + 32'd4;
                r_pcq_wr <= (r_pcq_wr == LP_QLAST) ? '0 : r_pcq_wr + QW'(1);
            end
            if (w_resp_take) begin
                r_pcq_rd <= (r_pcq_rd == LP_QLAST) ? '0 : r_pcq_rd + QW'(1);
            end
            if (w_resp_drop) begin
                r_discard_cnt <= r_discard_cnt - CW'(1);
            end
        end
    end

    // FIFO pointers, occupancy and registered head entry
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_head       <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr     <= w_rd_ptr_next;
            r_fifo_count <= w_count_next;
            r_head       <= w_head_next;
        end
    end

    assign bus.req          = w_req;
    assign bus.wr           = 1'b0;
    assign bus.size         = 2'b10;
    assign bus.addr         = w_addr;
    assign bus.wstrb        = 4'h0;
    assign bus.wdata        = 32'h0;
    assign bus.out_valid    = (r_fifo_count != '0);
    assign bus.out_pc       = r_head.pc;
    assign bus.out_inst     = r_head.inst;
    assign bus.out_has_exc  = r_head.has_exc;
    assign bus.out_ecode    = r_head.ecode;
    assign bus.out_esubcode = r_head.esubcode;
    assign bus.out_badv     = r_head.badv;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: per-cycle vector table for streaming, backpressure
// and redirect timing, then hand-written sequences for discard, ADEF, MMU fault
// and redirect-on-full corner cases.
module tb_if_fetch_queue;
    localparam logic [31:0] B = 32'h1c00_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if bus_if();

    if_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h1c00_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // MMU model: faults on one chosen page address while enabled
    logic        mmu_en   = 1'b0;
    logic [31:0] mmu_addr = 32'h0;
    always_comb begin
        bus_if.mmu_ecode_i    = (mmu_en && bus_if.addr == mmu_addr) ? 6'h3 : 6'h0;
        bus_if.mmu_esubcode_i = (mmu_en && bus_if.addr == mmu_addr) ? 9'h5 : 9'h0;
    end

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat     = 1;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [5:0]  ec;
        logic [8:0]  es;
        logic [31:0] badv;
    } obs_t;
    obs_t obs[$];

    logic        s_req, s_ov, s_exc, s_wr;
    logic [31:0] s_addr, s_pc, s_inst, s_badv, s_wdata;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[17];

    function automatic logic [31:0] minst(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic st,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_ov, input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic set_in(input logic rv, input logic [31:0] rpc, input logic st, input logic rdy);
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.stall_i        = st;
        bus_if.out_ready      = rdy;
    endtask

    // One clock: sample outputs at negedge, then act as the bus slave after posedge
    task automatic cycle();
        obs_t  o;
        pend_t p;
        logic  acc;
        @(negedge clk);
        s_req   = bus_if.req;      s_addr  = bus_if.addr;
        s_ov    = bus_if.out_valid; s_pc   = bus_if.out_pc;
        s_inst  = bus_if.out_inst;  s_exc  = bus_if.out_has_exc;
        s_badv  = bus_if.out_badv;  s_wr   = bus_if.wr;
        s_size  = bus_if.size;      s_wstrb = bus_if.wstrb;
        s_wdata = bus_if.wdata;
        if (s_ov && bus_if.out_ready) begin
            o.pc = bus_if.out_pc; o.inst = bus_if.out_inst; o.exc = bus_if.out_has_exc;
            o.ec = bus_if.out_ecode; o.es = bus_if.out_esubcode; o.badv = bus_if.out_badv;
            obs.push_back(o);
        end
        acc = s_req && bus_if.addr_ok;
        @(posedge clk);
        #1;
        if (acc) begin
            p.addr = s_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
        end
        cyc++;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus_if.data_ok = 1'b1;
            bus_if.rdata   = minst(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus_if.data_ok = 1'b0;
            bus_if.rdata   = 32'h0;
        end
    endtask

    task automatic drain();
        set_in(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (8) cycle();
        bus_if.stall_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nreq;
        int stale;
        vecs[0]  = mk(0, 0,       0, 1, 1, B+32'h00,  0, 0);
        vecs[1]  = mk(0, 0,       0, 1, 1, B+32'h04,  0, 0);
        vecs[2]  = mk(0, 0,       0, 1, 1, B+32'h08,  1, B+32'h00);
        vecs[3]  = mk(0, 0,       0, 0, 1, B+32'h0c,  1, B+32'h04);
        vecs[4]  = mk(0, 0,       0, 0, 1, B+32'h10,  1, B+32'h04);
        vecs[5]  = mk(0, 0,       0, 0, 0, 0,         1, B+32'h04);
        vecs[6]  = mk(0, 0,       0, 0, 0, 0,         1, B+32'h04);
        vecs[7]  = mk(0, 0,       0, 1, 0, 0,         1, B+32'h04);
        vecs[8]  = mk(0, 0,       0, 1, 1, B+32'h14,  1, B+32'h08);
        vecs[9]  = mk(0, 0,       0, 1, 1, B+32'h18,  1, B+32'h0c);
        vecs[10] = mk(1, B+32'h100, 0, 1, 0, 0,       1, B+32'h10);
        vecs[11] = mk(0, 0,       0, 1, 1, B+32'h100, 0, 0);
        vecs[12] = mk(0, 0,       0, 1, 1, B+32'h104, 0, 0);
        vecs[13] = mk(0, 0,       0, 1, 1, B+32'h108, 1, B+32'h100);
        vecs[14] = mk(0, 0,       1, 1, 0, 0,         1, B+32'h104);
        vecs[15] = mk(0, 0,       1, 1, 0, 0,         1, B+32'h108);
        vecs[16] = mk(0, 0,       0, 1, 1, B+32'h10c, 0, 0);

        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        bus_if.addr_ok = 1'b1;
        bus_if.data_ok = 1'b0;
        bus_if.rdata   = 32'h0;

        // reset state
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst.req", 32'(s_req), 32'd0);
        chk("rst.out_valid", 32'(s_ov), 32'd0);
        chk("rst.out_pc", s_pc, 32'h0);
        chk("rst.out_inst", s_inst, 32'h0);
        chk("rst.out_has_exc", 32'(s_exc), 32'd0);
        chk("rst.out_badv", s_badv, 32'h0);
        rst = 1'b0;

        // per-cycle vector table
        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].rv, vecs[i].rpc, vecs[i].st, vecs[i].rdy);
            cycle();
            chk($sformatf("vec%0d.req", i), 32'(s_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("vec%0d.addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d.out_valid", i), 32'(s_ov), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d.out_pc", i), s_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d.out_inst", i), s_inst, minst(vecs[i].e_pc));
            end
        end
        chk("const.wr", 32'(s_wr), 32'd0);
        chk("const.size", 32'(s_size), 32'd2);
        chk("const.wstrb", 32'(s_wstrb), 32'd0);
        chk("const.wdata", s_wdata, 32'h0);
        drain();

        // redirect with two requests in flight: both late responses dropped
        lat = 3;
        set_in(1'b1, B+32'h200, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("inflight2.req", 32'(s_req), 32'd1);
        chk("inflight2.addr", s_addr, B+32'h204);
        cycle();
        chk("maxout_block.req", 32'(s_req), 32'd0);
        set_in(1'b1, B+32'h100, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        obs.delete();
        repeat (12) cycle();
        chk("redir.count_ge2", 32'(obs.size() >= 2), 32'd1);
        if (obs.size() >= 2) begin
            chk("redir.first_pc", obs[0].pc, B+32'h100);
            chk("redir.first_inst", obs[0].inst, minst(B+32'h100));
            chk("redir.second_pc", obs[1].pc, B+32'h104);
        end
        stale = 0;
        foreach (obs[j]) if (obs[j].pc < B+32'h100 || obs[j].pc >= B+32'h200) stale++;
        chk("redir.stale", 32'(stale), 32'd0);
        drain();

        // misaligned redirect target: one ADEF entry, then no fetch until redirect
        lat = 1;
        set_in(1'b1, B+32'h102, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        obs.delete();
        nreq = 0;
        repeat (10) begin cycle(); if (s_req) nreq++; end
        chk("adef.noreq", 32'(nreq), 32'd0);
        chk("adef.count", 32'(obs.size()), 32'd1);
        if (obs.size() >= 1) begin
            chk("adef.pc", obs[0].pc, B+32'h102);
            chk("adef.inst", obs[0].inst, 32'h0);
            chk("adef.has_exc", 32'(obs[0].exc), 32'd1);
            chk("adef.ecode", 32'(obs[0].ec), 32'h8);
            chk("adef.esub", 32'(obs[0].es), 32'h0);
            chk("adef.badv", obs[0].badv, B+32'h102);
        end
        set_in(1'b1, B, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b1); cycle();
        chk("hold_exit.req", 32'(s_req), 32'd1);
        chk("hold_exit.addr", s_addr, B);
        drain();

        // MMU fault at 1c000010 with the previous fetch still in flight
        lat = 2;
        mmu_en = 1'b1;
        mmu_addr = B+32'h10;
        set_in(1'b1, B+32'h0c, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        obs.delete();
        nreq = 0;
        repeat (10) begin cycle(); if (s_req && s_addr == B+32'h10) nreq++; end
        chk("mmu.noreq_fault_addr", 32'(nreq), 32'd0);
        chk("mmu.count", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            chk("mmu.prior_pc", obs[0].pc, B+32'h0c);
            chk("mmu.prior_inst", obs[0].inst, minst(B+32'h0c));
            chk("mmu.prior_exc", 32'(obs[0].exc), 32'd0);
            chk("mmu.exc_pc", obs[1].pc, B+32'h10);
            chk("mmu.exc_flag", 32'(obs[1].exc), 32'd1);
            chk("mmu.exc_ecode", 32'(obs[1].ec), 32'h3);
            chk("mmu.exc_esub", 32'(obs[1].es), 32'h5);
            chk("mmu.exc_badv", obs[1].badv, B+32'h10);
            chk("mmu.exc_inst", obs[1].inst, 32'h0);
        end
        mmu_en = 1'b0;

        // redirect coinciding with data_ok and out_ready while credit is exhausted
        lat = 1;
        set_in(1'b1, B+32'h300, 1'b0, 1'b0); cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) cycle();
        set_in(1'b1, B+32'h400, 1'b0, 1'b1); cycle();
        chk("full.pre_out_valid", 32'(s_ov), 32'd1);
        chk("full.pre_out_pc", s_pc, B+32'h300);
        chk("full.pre_req", 32'(s_req), 32'd0);
        set_in(1'b0, 32'h0, 1'b0, 1'b1);
        obs.delete();
        cycle();
        chk("full.post_out_valid", 32'(s_ov), 32'd0);
        chk("full.post_req", 32'(s_req), 32'd1);
        chk("full.post_addr", s_addr, B+32'h400);
        repeat (6) cycle();
        chk("full.count_ge2", 32'(obs.size() >= 2), 32'd1);
        if (obs.size() >= 2) begin
            chk("full.first_pc", obs[0].pc, B+32'h400);
            chk("full.second_pc", obs[1].pc, B+32'h404);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
